clkdiv_cfg_loader: RTL and testbench

//  Serial configuration loader that sits directly upstream of the 4-channel clock divider/selector.

---
 rtl/clkdiv_cfg_if.sv | 26 ++
 rtl/clkdiv_cfg_loader.sv | 121 ++++++++++++
 tb/tb_clkdiv_cfg_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_cfg_if.sv
// Serial configuration bus between a config source and clkdiv_cfg_loader.
//   cfg_csn/cfg_sclk/cfg_sdata : 3-wire serial frame (driven by master)
//   cfg_word                   : committed parallel configuration
//   cfg_update/frame_err       : 1-cycle commit / discard pulses
//   busy                       : frame in progress
interface clkdiv_cfg_if #(
    parameter int unsigned CFG_WIDTH = 26
);
    logic                 cfg_csn;
    logic                 cfg_sclk;
    logic                 cfg_sdata;
    logic [CFG_WIDTH-1:0] cfg_word;
    logic                 cfg_update;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output cfg_csn, cfg_sclk, cfg_sdata,
        input  cfg_word, cfg_update, frame_err, busy
    );

    modport slave (
        input  cfg_csn, cfg_sclk, cfg_sdata,
        output cfg_word, cfg_update, frame_err, busy
    );
endinterface

// File: rtl/clkdiv_cfg_loader.sv
// Serial configuration loader for the 4-channel clock divider/selector.
// Oversamples a 3-wire frame (csn/sclk/sdata) in the clk domain and commits it
// atomically to cfg_word when the frame is exactly CFG_WIDTH bits long.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : clkdiv_cfg_if slave (serial inputs, cfg_word/cfg_update/frame_err/busy outputs)
// cfg_word map: [1:0] clock_select, [7:2] div_a, [13:8] div_b, [19:14] div_c, [25:20] div_d.
module clkdiv_cfg_loader #(
    parameter int unsigned          CFG_WIDTH   = 26,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [CFG_WIDTH-1:0] RESET_CFG   = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    clkdiv_cfg_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(CFG_WIDTH + 2);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                 csn_prev;
    logic                 sclk_prev;
    logic [CFG_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CFG_WIDTH-1:0] cfg_word_q;
    logic                 cfg_update_q;
    logic                 frame_err_q;
    logic                 busy_q;

    logic csn_s;
    logic sclk_s;
    logic sdata_s;
    logic csn_rise;
    logic csn_fall;
    logic sclk_rise;

    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync[SYNC_STAGES-1];
    assign csn_rise  = csn_s & ~csn_prev;
    assign csn_fall  = ~csn_s & csn_prev;
    assign sclk_rise = sclk_s & ~sclk_prev;

    // Input synchronisers plus edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_sync   <= '0;
            sclk_sync  <= '0;
            sdata_sync <= '0;
            csn_prev   <= 1'b0;
            sclk_prev  <= 1'b0;
        end else begin
            csn_sync   <= {csn_sync[SYNC_STAGES-2:0], bus.cfg_csn};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], bus.cfg_sclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], bus.cfg_sdata};
            csn_prev   <= csn_s;
            sclk_prev  <= sclk_s;
        end
    end

    // Frame FSM; csn rise takes priority over a coincident sclk rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            cfg_word_q   <= RESET_CFG;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        state   <= SHIFT;
                        shreg   <= '0;
                        bit_cnt <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (csn_rise) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (bit_cnt == CNT_W'(CFG_WIDTH)) begin
                            cfg_word_q   <= shreg;
                            cfg_update_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shreg <= {shreg[CFG_WIDTH-2:0], sdata_s};
                        // Saturate one past a full frame so overlong frames stay detectable
                        if (bit_cnt != CNT_W'(CFG_WIDTH + 1)) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_word   = cfg_word_q;
    assign bus.cfg_update = cfg_update_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_clkdiv_cfg_loader.sv
// Directed bench for clkdiv_cfg_loader: a frame table plus hand-written
// sequences for reset, out-of-frame sclk activity and commit latency.
module tb_clkdiv_cfg_loader;

    localparam int unsigned W = 26;

    logic clk;
    logic rst_n;

    clkdiv_cfg_if #(.CFG_WIDTH(W)) bus ();

    clkdiv_cfg_loader #(
        .CFG_WIDTH  (W),
        .SYNC_STAGES(2),
        .RESET_CFG  (26'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_upd    = 0;
    int n_ferr   = 0;
    int n_busy   = 0;

    // Pulse / busy activity monitors
    always @(negedge clk) begin
        if (bus.cfg_update === 1'b1) n_upd++;
        if (bus.frame_err === 1'b1)  n_ferr++;
        if (bus.busy === 1'b1)       n_busy++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Send one frame MSB first; race puts the last sclk rise on the csn rise cycle.
    // Traces record cfg_update/frame_err on the 4 negedges after csn goes high.
    task automatic send_frame(input logic [31:0] data, input int nbits, input bit race,
                              output logic [3:0] utr, output logic [3:0] etr);
        @(negedge clk);
        bus.cfg_csn = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.cfg_sdata = data[i];
            repeat (5) @(negedge clk);
            bus.cfg_sclk = 1'b1;
            if (race && i == 0) begin
                bus.cfg_csn = 1'b1;
            end else begin
                repeat (5) @(negedge clk);
                bus.cfg_sclk = 1'b0;
            end
        end
        if (!race) begin
            repeat (5) @(negedge clk);
            bus.cfg_csn = 1'b1;
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            utr[s] = bus.cfg_update;
            etr[s] = bus.frame_err;
        end
        bus.cfg_sclk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] data;
        int          nbits;
        bit          race;
        logic [25:0] exp_word;
        bit          exp_upd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [3:0] utr;
        logic [3:0] etr;
        int upd0;
        int err0;
        int busy0;

        vecs[0] = '{32'h03F2850E, 26, 1'b0, 26'h3F2850E, 1'b1, 1'b0}; // good
        vecs[1] = '{32'h01FFFFFF, 25, 1'b0, 26'h3F2850E, 1'b0, 1'b1}; // short
        vecs[2] = '{32'h05555555, 27, 1'b0, 26'h3F2850E, 1'b0, 1'b1}; // long
        vecs[3] = '{32'h00000001, 26, 1'b0, 26'h0000001, 1'b1, 1'b0}; // good after long
        vecs[4] = '{32'h03FFFFFF, 26, 1'b1, 26'h0000001, 1'b0, 1'b1}; // race
        vecs[5] = '{32'h02AAAAAA, 26, 1'b0, 26'h2AAAAAA, 1'b1, 1'b0}; // good

        rst_n         = 1'b0;
        bus.cfg_csn   = 1'b1;
        bus.cfg_sclk  = 1'b0;
        bus.cfg_sdata = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_word",   32'(bus.cfg_word),   32'h0);
        check("rst_update", 32'(bus.cfg_update), 32'd0);
        check("rst_err",    32'(bus.frame_err),  32'd0);
        check("rst_busy",   32'(bus.busy),       32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Frame table; pulses must land exactly SYNC_STAGES edges after csn high is sampled
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].nbits, vecs[v].race, utr, etr);
            check($sformatf("v%0d_word", v), 32'(bus.cfg_word), 32'(vecs[v].exp_word));
            check($sformatf("v%0d_upd_trace", v), 32'(utr), vecs[v].exp_upd ? 32'h4 : 32'h0);
            check($sformatf("v%0d_err_trace", v), 32'(etr), vecs[v].exp_err ? 32'h4 : 32'h0);
            check($sformatf("v%0d_busy_after", v), 32'(bus.busy), 32'd0);
        end
        check("sel_field", 32'(bus.cfg_word[1:0]), 32'd2);

        // sclk activity with csn high is ignored
        upd0 = n_upd; err0 = n_ferr; busy0 = n_busy;
        for (int t = 0; t < 10; t++) begin
            bus.cfg_sdata = t[0];
            repeat (4) @(negedge clk);
            bus.cfg_sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.cfg_sclk = 1'b0;
        end
        repeat (6) @(negedge clk);
        check("ign_upd",  32'(n_upd - upd0),   32'd0);
        check("ign_err",  32'(n_ferr - err0),  32'd0);
        check("ign_busy", 32'(n_busy - busy0), 32'd0);
        check("ign_word", 32'(bus.cfg_word),   32'h2AAAAAA);

        // Reset mid-frame with csn held low through release
        bus.cfg_csn = 1'b0;
        repeat (5) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            bus.cfg_sdata = 1'b1;
            repeat (4) @(negedge clk);
            bus.cfg_sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.cfg_sclk = 1'b0;
        end
        check("mid_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_word", 32'(bus.cfg_word),   32'h0);
        check("mid_rst_busy", 32'(bus.busy),       32'd0);
        check("mid_rst_upd",  32'(bus.cfg_update), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        upd0 = n_upd; err0 = n_ferr; busy0 = n_busy;
        repeat (12) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            repeat (4) @(negedge clk);
            bus.cfg_sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.cfg_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        bus.cfg_csn = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_busy", 32'(n_busy - busy0), 32'd0);
        check("post_rst_upd",  32'(n_upd - upd0),   32'd0);
        check("post_rst_err",  32'(n_ferr - err0),  32'd0);
        check("post_rst_word", 32'(bus.cfg_word),   32'h0);

        // Fresh frame after csn high then low commits normally
        send_frame(32'h02ABCDEF, 26, 1'b0, utr, etr);
        check("final_word",      32'(bus.cfg_word), 32'h2ABCDEF);
        check("final_upd_trace", 32'(utr),          32'h4);
        check("final_err_trace", 32'(etr),          32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
